// File: rtl/zrle_decoder.sv
// zrle_decoder: zero-run-length decoder.
// Input tokens are either literal bytes or zero-run codes. A run code N
// expands to N+1 zero bytes. Codes above MAX_RUN are clamped to MAX_RUN.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - input token present
//   in_ready   - decoder accepts the token this cycle
//   in_is_run  - 0: literal byte token, 1: zero-run token
//   in_data    - literal byte value or run code N
//   out_valid  - out_data holds a valid byte
//   out_ready  - sink consumes out_data this cycle
//   out_data   - decoded byte stream
//   out_zero   - out_valid and out_data is 8'h00
//   busy       - decoder is not idle
module zrle_decoder #(
    parameter int MAX_RUN = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_is_run,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_zero,
    output logic       busy
);

    localparam logic [7:0] MAX_CODE = 8'(MAX_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIT  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] remaining;
    // Cleared by reset, set on the first clock edge afterwards, so in_ready
    // stays low until the decoder has seen a clean edge out of reset.
    logic       armed;

    logic       consume;
    logic       last_byte;
    logic       accept;

    function automatic logic [7:0] clamp_run(input logic [7:0] code);
        return (code > MAX_CODE) ? MAX_CODE : code;
    endfunction

    // Handshake decode. A byte is final in LIT always, and in RUN once the
    // remaining counter has reached zero.
    always_comb begin
        consume   = out_valid && out_ready;
        last_byte = consume && ((state == LIT) ||
                                ((state == RUN) && (remaining == 8'd0)));
        accept    = in_valid && in_ready;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_is_run ? RUN : LIT;
                end
            end
            LIT, RUN: begin
                if (last_byte) begin
                    if (accept) begin
                        state_nxt = in_is_run ? RUN : LIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state != IDLE);
        busy      = (state != IDLE);
        in_ready  = armed && ((state == IDLE) || last_byte);
        out_zero  = out_valid && (out_data == 8'h00);
    end

    // Output byte and run counter. Both hold while the sink stalls because
    // they only change on an accepted token or a consumed run byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 8'h00;
            remaining <= 8'd0;
        end else if (accept) begin
            out_data  <= in_is_run ? 8'h00 : in_data;
            remaining <= in_is_run ? clamp_run(in_data) : 8'd0;
        end else if (consume && (state == RUN) && (remaining != 8'd0)) begin
            remaining <= remaining - 8'd1;
        end
    end

endmodule

// File: doc/zrle_decoder.md
ZRLE_DECODER -- requirements
Module: zrle_decoder

Interface
REQ-001 SHALL have parameter MAX_RUN, default 255, the largest legal run code (8-bit); codes above it are clamped to MAX_RUN.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  an input token is present.
REQ-005 SHALL have port in_ready  output  1  the decoder accepts the token this cycle.
REQ-006 SHALL have port in_is_run  input  1  0: literal byte token; 1: zero-run token.
REQ-007 SHALL have port in_data  input  8  literal byte value, or run code N meaning N+1 zero bytes.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-009 SHALL have port out_ready  input  1  the sink consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  8  decoded byte stream.
REQ-011 SHALL have port out_zero  output  1  high exactly when out_valid=1 and out_data==8'h00.
REQ-012 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-013 SHALL transfer a token only when in_valid && in_ready at a rising edge, and an output byte only when out_valid && out_ready.
REQ-014 SHALL implement a three-state FSM: IDLE, LIT (one literal byte pending), RUN (zero bytes pending).
REQ-015 SHALL drive in_ready=1 in IDLE, and also in LIT/RUN during the cycle the final pending byte is consumed (back-to-back, no bubble).
REQ-016 SHALL drive in_ready=0 in all other cycles.
REQ-017 SHALL, on accepting a literal token, register out_data=in_data and enter LIT, with out_valid=1 on the next cycle (latency 1).
REQ-018 SHALL, on accepting a run token with code N, register out_data=8'h00 and remaining=min(N,MAX_RUN), then enter RUN with out_valid=1 on the next cycle.
REQ-019 SHALL, in RUN, decrement the 8-bit remaining counter on each consumed byte while it is nonzero; a consumed byte with remaining==0 is the final byte.
REQ-020 SHALL therefore emit exactly min(N,MAX_RUN)+1 zero bytes per run token: N=0 gives 1 byte, N=255 gives 256 bytes; the counter never wraps.
REQ-021 SHALL, on consuming the final byte of LIT or RUN:
- go to the new token's state if a token is accepted in the same cycle;
- otherwise return to IDLE with out_valid=0.
REQ-022 SHALL hold out_valid, out_data and remaining unchanged while out_valid=1 and out_ready=0 (stall).
REQ-023 SHALL treat a literal 8'h00 token identically to any literal: exactly one zero byte.
REQ-024 SHALL keep out_valid=0 in IDLE, and SHALL ignore in_is_run and in_data whenever no token is accepted.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, force state=IDLE, out_valid=0, out_data=8'h00, remaining=0, out_zero=0 and busy=0.
REQ-026 SHALL hold in_ready=0 while rst=1, and drive in_ready=1 from the first clk edge after rst falls.
REQ-027 SHALL discard any partially emitted run or pending literal when rst asserts mid-operation; no further bytes of that token appear after reset.

Verification
REQ-028 SHALL pass: literal 8'hA5 with out_ready=1 -> next cycle out_valid=1, out_data=A5, out_zero=0; one cycle later IDLE.
REQ-029 SHALL pass: run N=3 with out_ready=1 -> four consecutive zero bytes, out_zero=1 on each, in_ready=1 on the fourth.
REQ-030 SHALL pass: run N=255 -> exactly 256 zero bytes, then out_valid=0; run N=0 -> exactly one zero byte.
REQ-031 SHALL pass: run N=2 followed by literal 8'h11 presented continuously -> bytes 00,00,00,11 with no idle cycle between them.
REQ-032 SHALL pass: out_ready toggling 1,0,0,1 during run N=5 -> out_data and remaining held during stalls; still 6 bytes total.
REQ-033 SHALL pass: rst pulse after 2 of 6 run bytes -> out_valid=0 immediately; a later literal 8'h7E decodes normally with no leftover zeros.
